// File: rtl/dice_game_pkg.sv
// Shared types and constants for the dice_game craps controller:
// FSM state encoding, die/sum widths, craps rule constants and the
// 7-segment decode table used by the top level.
package dice_game_pkg;

    localparam int unsigned DIE_W = 3;
    localparam int unsigned SUM_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        POINT,
        WON,
        LOST
    } state_t;

    // Natural wins on the come-out roll
    localparam logic [SUM_W-1:0] NAT_SEVEN    = 4'd7;
    localparam logic [SUM_W-1:0] NAT_ELEVEN   = 4'd11;

    // Craps (loss) on the come-out roll
    localparam logic [SUM_W-1:0] CRAPS_TWO    = 4'd2;
    localparam logic [SUM_W-1:0] CRAPS_THREE  = 4'd3;
    localparam logic [SUM_W-1:0] CRAPS_TWELVE = 4'd12;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ONE   = 7'h06;
    localparam logic [6:0] SEG_TWO   = 7'h5B;
    localparam logic [6:0] SEG_THREE = 7'h4F;
    localparam logic [6:0] SEG_FOUR  = 7'h66;
    localparam logic [6:0] SEG_FIVE  = 7'h6D;
    localparam logic [6:0] SEG_SIX   = 7'h7D;

    // Die value to active-high segment pattern; 0 and 7 are blank
    function automatic logic [6:0] seg_decode(input logic [DIE_W-1:0] value);
        logic [6:0] pattern;
        case (value)
            3'd1:    pattern = SEG_ONE;
            3'd2:    pattern = SEG_TWO;
            3'd3:    pattern = SEG_THREE;
            3'd4:    pattern = SEG_FOUR;
            3'd5:    pattern = SEG_FIVE;
            3'd6:    pattern = SEG_SIX;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/dice_counters.sv
// Cascaded free-running die counters. c1 cycles 1..6 every clock; c2
// steps once each time c1 wraps from 6, so together they walk all 36
// die combinations. Both sit at 1 while rst is high.
module dice_counters
    import dice_game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [DIE_W-1:0] c1,
    output logic [DIE_W-1:0] c2
);

    // Advance c1 every cycle and carry into c2 on c1 wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            c1 <= 3'd1;
            c2 <= 3'd1;
        end else begin
            c1 <= (c1 == 3'd6) ? 3'd1 : c1 + 3'd1;
            if (c1 == 3'd6) begin
                c2 <= (c2 == 3'd6) ? 3'd1 : c2 + 3'd1;
            end
        end
    end

endmodule

// File: rtl/dice_game.sv
// Two-dice craps game controller. On each rising edge of starting_roll the
// current counter values are latched as the dice, summed, and judged by the
// craps rules; win/lose are sticky until rst.
// Optional macro DICE_GAME_ROLL_SYNC_EN adds a 2-flop synchronizer on
// starting_roll ahead of the edge detector (rolls land 2 edges later).
module dice_game
    import dice_game_pkg::*;
#(
    parameter logic SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             starting_roll,
    output logic [DIE_W-1:0] dice1_out,
    output logic [DIE_W-1:0] dice2_out,
    output logic [6:0]       segdisp_1,
    output logic [6:0]       segdisp_2,
    output logic             win,
    output logic             lose
);

    logic [DIE_W-1:0] c1;
    logic [DIE_W-1:0] c2;
    logic             roll_src;
    logic             starting_roll_q;
    logic             roll;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] point;
    state_t           state;

    dice_counters u_counters (
        .clk (clk),
        .rst (rst),
        .c1  (c1),
        .c2  (c2)
    );

`ifdef DICE_GAME_ROLL_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Two-flop synchronizer for the asynchronous pushbutton input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= starting_roll;
            sync_q2 <= sync_q1;
        end
    end

    assign roll_src = sync_q2;
`else
    assign roll_src = starting_roll;
`endif

    // Previous-value register for rising-edge detection of the roll request
    always_ff @(posedge clk) begin
        if (rst) begin
            starting_roll_q <= 1'b0;
        end else begin
            starting_roll_q <= roll_src;
        end
    end

    assign roll = roll_src & ~starting_roll_q;
    assign sum  = SUM_W'(c1) + SUM_W'(c2);

    // Game FSM: latch dice and judge the sum on each roll edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            point     <= '0;
            dice1_out <= '0;
            dice2_out <= '0;
            win       <= 1'b0;
            lose      <= 1'b0;
        end else if (roll) begin
            case (state)
                IDLE: begin
                    dice1_out <= c1;
                    dice2_out <= c2;
                    if (sum == NAT_SEVEN || sum == NAT_ELEVEN) begin
                        state <= WON;
                        win   <= 1'b1;
                    end else if (sum == CRAPS_TWO || sum == CRAPS_THREE ||
                                 sum == CRAPS_TWELVE) begin
                        state <= LOST;
                        lose  <= 1'b1;
                    end else begin
                        point <= sum;
                        state <= POINT;
                    end
                end
                POINT: begin
                    dice1_out <= c1;
                    dice2_out <= c2;
                    if (sum == point) begin
                        state <= WON;
                        win   <= 1'b1;
                    end else if (sum == NAT_SEVEN) begin
                        state <= LOST;
                        lose  <= 1'b1;
                    end
                end
                default: begin
                    // WON / LOST are terminal until rst
                end
            endcase
        end
    end

    assign segdisp_1 = seg_decode(dice1_out) ^ {7{SEG_ACTIVE_LOW}};
    assign segdisp_2 = seg_decode(dice2_out) ^ {7{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_dice_game.sv
// Scoreboard bench for dice_game: a craps reference model computes the
// expected dice/flags per roll from the closed-form counter values, pushes
// them with their due cycle, and a negedge monitor compares every cycle.
module tb_dice_game;

    localparam logic SEG_AL = 1'b0;
`ifdef DICE_GAME_ROLL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       starting_roll = 1'b0;
    logic [2:0] dice1_out, dice2_out;
    logic [6:0] segdisp_1, segdisp_2;
    logic       win, lose;

    dice_game #(.SEG_ACTIVE_LOW(SEG_AL)) dut (
        .clk           (clk),
        .rst           (rst),
        .starting_roll (starting_roll),
        .dice1_out     (dice1_out),
        .dice2_out     (dice2_out),
        .segdisp_1     (segdisp_1),
        .segdisp_2     (segdisp_2),
        .win           (win),
        .lose          (lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [2:0] d1;
        logic [2:0] d2;
        logic       w;
        logic       l;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    bit         have_cur = 0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         nrun = 0;
    logic [6:0] seg_tab [8];

    // model state
    int m_d1, m_d2, m_point;
    bit m_win, m_lose;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) nrun <= 0;
        else     nrun <= nrun + 1;
    end

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // monitor: retire due expectations, then compare all outputs
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            cur = q.pop_front();
            have_cur = 1;
        end
        if (have_cur) begin
            check("dice1", int'(dice1_out), int'(cur.d1));
            check("dice2", int'(dice2_out), int'(cur.d2));
            check("seg1", int'(segdisp_1), int'(seg_tab[cur.d1] ^ {7{SEG_AL}}));
            check("seg2", int'(segdisp_2), int'(seg_tab[cur.d2] ^ {7{SEG_AL}}));
            check("win", int'(win), int'(cur.w));
            check("lose", int'(lose), int'(cur.l));
        end
    end

    function automatic void push_exp(input int due);
        exp_t e;
        e.due = due;
        e.d1  = 3'(m_d1);
        e.d2  = 3'(m_d2);
        e.w   = m_win;
        e.l   = m_lose;
        q.push_back(e);
    endfunction

    // Craps rules applied to the dice seen at run edge n
    function automatic void model_roll(input int n);
        int a, b, s;
        if (m_win || m_lose) return;
        a = (n % 6) + 1;
        b = ((n / 6) % 6) + 1;
        s = a + b;
        m_d1 = a;
        m_d2 = b;
        if (m_point == 0) begin
            if (s == 7 || s == 11)                m_win = 1;
            else if (s == 2 || s == 3 || s == 12) m_lose = 1;
            else                                  m_point = s;
        end else begin
            if (s == m_point)  m_win = 1;
            else if (s == 7)   m_lose = 1;
        end
    endfunction

    // called at a negedge; leaves rst low at a negedge with nrun == 0
    task automatic do_reset(input int len);
        rst = 1'b1;
        starting_roll = 1'b0;
        m_d1 = 0; m_d2 = 0; m_point = 0; m_win = 0; m_lose = 0;
        push_exp(cyc + 1);
        repeat (len) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_to(input int target);
        int guard;
        guard = 0;
        while (nrun + LAT < target && guard < 200) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic do_roll(input int hold);
        model_roll(nrun + LAT);
        push_exp(cyc + 1 + LAT);
        starting_roll = 1'b1;
        repeat (hold) @(negedge clk);
        starting_roll = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        seg_tab[0] = 7'h00; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h00;

        @(negedge clk);
        // craps loss at n=0 (1/1), then a further roll is ignored
        do_reset(2);
        do_roll(1);
        wait_to(9);
        do_roll(1);

        // point 4 at n=2, win at n=12 (1/3)
        @(negedge clk);
        do_reset(2);
        wait_to(2);
        do_roll(1);
        wait_to(12);
        do_roll(1);

        // point 4, no decision at n=13 (2/3), lose at n=25 (2/5)
        do_reset(1);
        wait_to(2);
        do_roll(1);
        wait_to(13);
        do_roll(1);
        wait_to(25);
        do_roll(1);

        // natural win at n=5 (6/1)
        do_reset(2);
        wait_to(5);
        do_roll(1);

        // held request gives one roll only
        do_reset(2);
        wait_to(2);
        do_roll(20);
        do_roll(2);

        // randomized games, some interrupted by reset mid-game
        for (int g = 0; g < 30; g++) begin
            int nrolls;
            do_reset($urandom_range(1, 3));
            nrolls = $urandom_range(1, 10);
            for (int r = 0; r < nrolls; r++) begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
                do_roll($urandom_range(1, 4));
            end
        end

        do_reset(2);
        repeat (4) @(negedge clk);
        check("queue_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
